iic_slave_mem: RTL and testbench
================================

Name: iic_slave_mem

Overview:
- I2C responder (target) with an internal byte-addressable register memory, modelled on the 24C02 protocol.
- It is the far end of the `iic` master. The bench connects both on a shared open-drain SCL/SDA pair, so the master's write and read sequences can be checked end to end.
- Fully synchronous to `clock`: SCL and SDA are oversampled, not used as clocks.
- Requires f(clock) >= 16 x f(SCL).

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address (control byte 0xA0 for write, 0xA1 for read).
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W bytes.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low.
- SCL  input  1  I2C clock from master, externally pulled up.
- SDA  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
- oAddr  output  ADDR_W  current word pointer.
- oData  output  8  last byte written to memory, or last byte loaded for transmit.
- oWrValid  output  1  1-cycle pulse when a byte is stored to memory.
- oRdValid  output  1  1-cycle pulse when a byte is loaded for transmit.
- oBusy  output  1  high from an addressed START (device-address match) until STOP.

Interface decided: reset reset, asynchronous, active-low; clock clock.

Behaviour:
- **Reset values:** SDA released (z); oAddr=0; oData=0x00; oWrValid, oRdValid, oBusy = 0; state IDLE; all memory bytes 0x00.
- **Input conditioning:**
  - SCL and SDA pass through 2-FF synchronizers plus one history register.
  - SCL rise/fall = sync/history pair 01/10.
  - START = SDA 1->0 while synced SCL = 1.
  - STOP = SDA 0->1 while synced SCL = 1.
- **Bit timing:**
  - Input bits are sampled on detected SCL rise, MSB first.
  - SDA drive changes only on the cycle after a detected SCL fall.
- **States:** IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- **IDLE:** waits for START -> DEV (bit counter cleared).
- **DEV:** shifts 8 bits.
  - Bits[7:1] == DEV_ADDR -> DEV_ACK; oBusy = 1.
  - Otherwise -> IDLE with SDA untouched.
- **DEV_ACK:**
  - Pull SDA low from the fall after bit 8; release on the fall after the 9th rise.
  - R/W = 0 -> WADDR.
  - R/W = 1 -> load mem[oAddr] into the TX shifter, pulse oRdValid, -> RDATA. The first data bit is driven on the same fall that releases ACK.
- **WADDR:** 8 bits -> oAddr (the low ADDR_W bits of the received byte); then ACK (WADDR_ACK) -> WDATA.
- **WDATA:**
  - 8 bits -> mem[oAddr]; oData = byte; oWrValid pulse.
  - oAddr increments, wrapping 2**ADDR_W-1 -> 0.
  - Then ACK (WDATA_ACK) -> WDATA.
- **RDATA:**
  - Drive 0 = pull low; drive 1 = release.
  - After 8 bits, release SDA -> RACK.
- **RACK:** sample master's ACK on the 9th rise.
  - ACK (0): oAddr++ with wrap, load next byte, pulse oRdValid, -> RDATA.
  - NACK (1): -> IDLE, SDA released.
- **STOP in any state:** -> IDLE, SDA released, oBusy = 0. A partial data byte is discarded; oAddr is retained.
- **Repeated START in any state:** -> DEV, SDA released. oAddr is retained, which supports random read (write word address, Sr, read).
- **Simultaneous events:** START/STOP detection has priority over bit sampling in the same cycle.
- **Reset mid-transfer:** immediate return to reset values; SDA released.

Optional Feature:
- Macro: IIC_SLAVE_WP_EN.
- **Defined:**
  - Adds port iWP (input, 1): write protect.
  - While iWP = 1, WDATA bytes are NACKed (SDA left released in the 9th clock).
  - Memory and oAddr are unchanged and oWrValid does not pulse.
  - Device-address and word-address bytes are still ACKed.
- **Undefined:** no iWP port; all writes are stored.

Test Plan:
- Reset asserted mid-byte -> SDA=z, oBusy=0, oAddr=0 within 1 cycle; a following START + 0xA0 is ACKed normally.
- Write 0xA0,0x00,0xAB; 0xA0,0x01,0xCD; 0xA0,0x02,0xEF (three separate transactions, each ended with STOP) -> every byte ACKed; mem[0..2] = AB, CD, EF; three oWrValid pulses; oAddr = 3 after the last.
- Random read: 0xA0,0x01, Sr, 0xA1; master ACK, ACK, NACK -> SDA returns CD, EF, 00; oRdValid pulses 3x; IDLE after NACK and STOP.
- Wrong address: control byte 0xA2 -> SDA stays z on the 9th clock; memory untouched; oBusy stays 0.
- Wrap: write 0xA0,0xFF,0x11,0x22 -> mem[FF] = 11, mem[00] = 22, oAddr = 0x01.
- IIC_SLAVE_WP_EN with iWP = 1: write 0xA0,0x00,0x55 -> data byte NACKed; mem[0] unchanged; no oWrValid pulse.

Source files
------------

// File: rtl/iic_slave_mem.sv
// iic_slave_mem: I2C target with a 2**ADDR_W byte register file, 24C02-style protocol.
// Optional write protect (iWP input) is enabled by defining IIC_SLAVE_WP_EN.
`timescale 1ns/1ps
module iic_slave_mem #(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clock,
   input  logic              reset,
`ifdef IIC_SLAVE_WP_EN
   input  logic              iWP,
`endif
   input  logic              SCL,
   inout  wire               SDA,
   output logic [ADDR_W-1:0] oAddr,
   output logic [7:0]        oData,
   output logic              oWrValid,
   output logic              oRdValid,
   output logic              oBusy
);

   localparam int unsigned        DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      DEV       = 4'd1,
      DEV_ACK   = 4'd2,
      WADDR     = 4'd3,
      WADDR_ACK = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RACK      = 4'd8
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          scl_q, scl_d, sda_q, sda_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [6:0]          shift_q, shift_d;
   logic [7:0]          tx_q, tx_d;
   logic                rw_q, rw_d;
   logic                nack_q, nack_d;
   logic                sda_oe_q, sda_oe_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                wr_valid_q, wr_valid_d;
   logic                rd_valid_q, rd_valid_d;
   logic                busy_q, busy_d;
   logic [7:0]          mem_q [0:DEPTH-1];

   logic                scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
   logic                dev_hit_s, wp_s, mem_we_s;
   logic [7:0]          byte_s, rd_byte_s;
   logic [ADDR_W-1:0]   addr_inc_s, rd_addr_s;

`ifdef IIC_SLAVE_WP_EN
   assign wp_s = iWP;
`else
   assign wp_s = 1'b0;
`endif

   // [0] first sync stage, [1] synchronized value, [2] history
   assign scl_d      = {scl_q[1:0], SCL};
   assign sda_d      = {sda_q[1:0], SDA};
   assign sda_s      = sda_q[1];
   assign scl_rise_s = scl_q[1] & ~scl_q[2];
   assign scl_fall_s = ~scl_q[1] & scl_q[2];
   assign start_s    = scl_q[1] & sda_q[2] & ~sda_q[1];
   assign stop_s     = scl_q[1] & ~sda_q[2] & sda_q[1];

   assign byte_s     = {shift_q, sda_s};
   assign dev_hit_s  = (byte_s[7:1] == DEV_ADDR);
   assign addr_inc_s = addr_q + ADDR_ONE;
   assign rd_addr_s  = (state_q == RACK) ? addr_inc_s : addr_q;
   assign rd_byte_s  = mem_q[rd_addr_s];

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         scl_q      <= 3'b111;
         sda_q      <= 3'b111;
         cnt_q      <= 4'd0;
         shift_q    <= 7'd0;
         tx_q       <= 8'd0;
         rw_q       <= 1'b0;
         nack_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         addr_q     <= {ADDR_W{1'b0}};
         data_q     <= 8'd0;
         wr_valid_q <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_q      <= scl_d;
         sda_q      <= sda_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         rw_q       <= rw_d;
         nack_q     <= nack_d;
         sda_oe_q   <= sda_oe_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_valid_q <= wr_valid_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
      end
   end

   // Register-file storage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
      end else if (mem_we_s) begin
         mem_q[addr_q] <= byte_s;
      end else begin
         mem_q[addr_q] <= mem_q[addr_q];
      end
   end

   // Next-state logic; bus conditions override bit events
   always_comb begin
      state_d = state_q;
      if (start_s) begin
         state_d = DEV;
      end else if (stop_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            DEV: begin
               if (scl_rise_s && cnt_q == 4'd7) state_d = dev_hit_s ? DEV_ACK : IDLE;
               else                             state_d = DEV;
            end
            WADDR: begin
               if (scl_rise_s && cnt_q == 4'd7) state_d = WADDR_ACK;
               else                             state_d = WADDR;
            end
            WDATA: begin
               if (scl_rise_s && cnt_q == 4'd7) state_d = WDATA_ACK;
               else                             state_d = WDATA;
            end
            DEV_ACK: begin
               if (scl_fall_s && cnt_q == 4'd9) state_d = rw_q ? RDATA : WADDR;
               else                             state_d = DEV_ACK;
            end
            WADDR_ACK: begin
               if (scl_fall_s && cnt_q == 4'd9) state_d = WDATA;
               else                             state_d = WADDR_ACK;
            end
            WDATA_ACK: begin
               if (scl_fall_s && cnt_q == 4'd9) state_d = WDATA;
               else                             state_d = WDATA_ACK;
            end
            RDATA: begin
               if (scl_fall_s && cnt_q == 4'd8) state_d = RACK;
               else                             state_d = RDATA;
            end
            RACK: begin
               if (scl_rise_s && sda_s)              state_d = IDLE;
               else if (scl_fall_s && cnt_q == 4'd9) state_d = RDATA;
               else                                  state_d = RACK;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output and datapath logic: shifting, ACK drive, memory access
   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      rw_d       = rw_q;
      nack_d     = nack_q;
      sda_oe_d   = sda_oe_q;
      addr_d     = addr_q;
      data_d     = data_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      rd_valid_d = 1'b0;
      mem_we_s   = 1'b0;
      if (start_s) begin
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else if (stop_s) begin
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            DEV, WADDR, WDATA: begin
               if (scl_rise_s) begin
                  shift_d = byte_s[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  nack_d  = 1'b0;
                  if (cnt_q != 4'd7) begin
                     rw_d = rw_q;
                  end else if (state_q == DEV) begin
                     rw_d   = sda_s;
                     busy_d = busy_q | dev_hit_s;
                  end else if (state_q == WADDR) begin
                     addr_d = byte_s[ADDR_W-1:0];
                  end else if (wp_s) begin
                     nack_d = 1'b1;
                  end else begin
                     mem_we_s   = 1'b1;
                     data_d     = byte_s;
                     wr_valid_d = 1'b1;
                     addr_d     = addr_inc_s;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            DEV_ACK, WADDR_ACK, WDATA_ACK: begin
               if (scl_fall_s && cnt_q == 4'd8) begin
                  sda_oe_d = ~nack_q;
               end else if (scl_rise_s && cnt_q == 4'd8) begin
                  cnt_d = 4'd9;
               end else if (scl_fall_s && cnt_q == 4'd9) begin
                  cnt_d = 4'd0;
                  if (state_q == DEV_ACK && rw_q) begin
                     // first data bit goes out on the same fall that ends the ACK
                     tx_d       = {rd_byte_s[6:0], 1'b0};
                     sda_oe_d   = ~rd_byte_s[7];
                     data_d     = rd_byte_s;
                     rd_valid_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            RDATA: begin
               if (scl_rise_s) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall_s && cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
               end else if (scl_fall_s) begin
                  sda_oe_d = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
               end else begin
                  cnt_d = cnt_q;
               end
            end
            RACK: begin
               if (scl_rise_s && sda_s) begin
                  cnt_d    = 4'd0;
                  sda_oe_d = 1'b0;
               end else if (scl_rise_s) begin
                  cnt_d = 4'd9;
               end else if (scl_fall_s && cnt_q == 4'd9) begin
                  cnt_d      = 4'd0;
                  addr_d     = addr_inc_s;
                  tx_d       = {rd_byte_s[6:0], 1'b0};
                  sda_oe_d   = ~rd_byte_s[7];
                  data_d     = rd_byte_s;
                  rd_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
   assign oAddr    = addr_q;
   assign oData    = data_q;
   assign oWrValid = wr_valid_q;
   assign oRdValid = rd_valid_q;
   assign oBusy    = busy_q;

endmodule

// File: tb/tb_iic_slave_mem.sv
// Directed bench for iic_slave_mem: a behavioural I2C master on an open-drain bus
// with a pull-up drives write, random-read, wrong-address, wrap and reset sequences.
`timescale 1ns/1ps
module tb_iic_slave_mem;

   localparam int Q = 80;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       scl   = 1'b1;
   logic       m_sda_oe = 1'b0;
   wire        sda_w;
   logic [7:0] oAddr;
   logic [7:0] oData;
   logic       oWrValid, oRdValid, oBusy;
`ifdef IIC_SLAVE_WP_EN
   logic       wp = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;

   pullup (sda_w);
   assign sda_w = m_sda_oe ? 1'b0 : 1'bz;

   iic_slave_mem #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
      .clock    (clock),
      .reset    (reset),
`ifdef IIC_SLAVE_WP_EN
      .iWP      (wp),
`endif
      .SCL      (scl),
      .SDA      (sda_w),
      .oAddr    (oAddr),
      .oData    (oData),
      .oWrValid (oWrValid),
      .oRdValid (oRdValid),
      .oBusy    (oBusy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (oWrValid) wr_cnt <= wr_cnt + 1;
      if (oRdValid) rd_cnt <= rd_cnt + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      m_sda_oe = ~b;
      #(Q); scl = 1'b1;
      #(Q); r = sda_w;
      #(Q); scl = 1'b0;
      #(Q);
   endtask

   task automatic i2c_start();
      m_sda_oe = 1'b0;
      #(Q); scl = 1'b1;
      #(Q); m_sda_oe = 1'b1;
      #(Q); scl = 1'b0;
      #(Q);
   endtask

   task automatic i2c_stop();
      m_sda_oe = 1'b1;
      #(Q); scl = 1'b1;
      #(Q); m_sda_oe = 1'b0;
      #(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic ack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         b[i] = r;
      end
      bit_xfer(ack, r);
   endtask

   logic [7:0] wa [3] = '{8'h00, 8'h01, 8'h02};
   logic [7:0] wd [3] = '{8'hAB, 8'hCD, 8'hEF};
   logic [7:0] rexp [3] = '{8'hCD, 8'hEF, 8'h00};

   initial begin
      logic       ack;
      logic       r;
      logic [7:0] rb;
      int         wr0;

      #2;
      check_value("rst_sda", sda_w, 1'b1);
      check_value("rst_busy", oBusy, 1'b0);
      check_value("rst_addr", oAddr, 8'h00);
      check_value("rst_data", oData, 8'h00);
      check_value("rst_wrv", oWrValid, 1'b0);
      #40 reset = 1'b1;
      #(Q);

      // three single-byte writes
      for (int i = 0; i < 3; i++) begin
         i2c_start();
         wr_byte(8'hA0, ack);  check_value("wr_ctl_ack", ack, 1'b0);
         check_value("wr_busy", oBusy, 1'b1);
         wr_byte(wa[i], ack);  check_value("wr_addr_ack", ack, 1'b0);
         wr_byte(wd[i], ack);  check_value("wr_data_ack", ack, 1'b0);
         i2c_stop();
         check_value("wr_odata", oData, wd[i]);
         check_value("wr_oaddr", oAddr, wa[i] + 8'h01);
         check_value("wr_idle_busy", oBusy, 1'b0);
      end
      check_value("wr_pulses", wr_cnt, 32'd3);

      // random read from word 1
      i2c_start();
      wr_byte(8'hA0, ack);  check_value("rr_ctl_ack", ack, 1'b0);
      wr_byte(8'h01, ack);  check_value("rr_addr_ack", ack, 1'b0);
      i2c_start();
      wr_byte(8'hA1, ack);  check_value("rr_rd_ack", ack, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rd_byte((i == 2) ? 1'b1 : 1'b0, rb);
         check_value("rr_byte", rb, rexp[i]);
      end
      check_value("rr_released", sda_w, 1'b1);
      i2c_stop();
      check_value("rr_pulses", rd_cnt, 32'd3);
      check_value("rr_oaddr", oAddr, 8'h03);
      check_value("rr_busy", oBusy, 1'b0);

      // wrong device address
      wr0 = wr_cnt;
      i2c_start();
      wr_byte(8'hA2, ack);  check_value("wa_nack", ack, 1'b1);
      check_value("wa_busy", oBusy, 1'b0);
      wr_byte(8'h00, ack);  check_value("wa_data_nack", ack, 1'b1);
      i2c_stop();
      check_value("wa_wr", wr_cnt, wr0);
      check_value("wa_oaddr", oAddr, 8'h03);

      // address wrap on write, then read back across the wrap
      i2c_start();
      wr_byte(8'hA0, ack);  check_value("wp_ctl_ack", ack, 1'b0);
      wr_byte(8'hFF, ack);  check_value("wrap_addr_ack", ack, 1'b0);
      wr_byte(8'h11, ack);  check_value("wrap_d0_ack", ack, 1'b0);
      wr_byte(8'h22, ack);  check_value("wrap_d1_ack", ack, 1'b0);
      i2c_stop();
      check_value("wrap_oaddr", oAddr, 8'h01);
      check_value("wrap_wr", wr_cnt, wr0 + 2);
      i2c_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'hFF, ack);
      i2c_start();
      wr_byte(8'hA1, ack);  check_value("wrap_rd_ack", ack, 1'b0);
      rd_byte(1'b0, rb);    check_value("wrap_memff", rb, 8'h11);
      rd_byte(1'b1, rb);    check_value("wrap_mem00", rb, 8'h22);
      i2c_stop();
      check_value("wrap_rd_oaddr", oAddr, 8'h00);

`ifdef IIC_SLAVE_WP_EN
      wp  = 1'b1;
      wr0 = wr_cnt;
      i2c_start();
      wr_byte(8'hA0, ack);  check_value("wp_ctl_ack", ack, 1'b0);
      wr_byte(8'h00, ack);  check_value("wp_addr_ack", ack, 1'b0);
      wr_byte(8'h55, ack);  check_value("wp_data_nack", ack, 1'b1);
      i2c_stop();
      check_value("wp_wr", wr_cnt, wr0);
      check_value("wp_oaddr", oAddr, 8'h00);
      wp = 1'b0;
      i2c_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h00, ack);
      i2c_start();
      wr_byte(8'hA1, ack);
      rd_byte(1'b1, rb);    check_value("wp_mem00", rb, 8'h22);
      i2c_stop();
`endif

      // reset while the target is holding an ACK low
      i2c_start();
      wr_byte(8'hA0, ack);
      for (int i = 7; i >= 0; i--) bit_xfer(((8'h05 >> i) & 8'h01) != 8'h00, r);
      check_value("mr_ack_low", sda_w, 1'b0);
      reset = 1'b0;
      #10;
      check_value("mr_sda", sda_w, 1'b1);
      check_value("mr_busy", oBusy, 1'b0);
      check_value("mr_oaddr", oAddr, 8'h00);
      m_sda_oe = 1'b0;
      scl      = 1'b1;
      #20 reset = 1'b1;
      #(Q);
      i2c_start();
      wr_byte(8'hA0, ack);  check_value("mr_ctl_ack", ack, 1'b0);
      wr_byte(8'h00, ack);
      i2c_start();
      wr_byte(8'hA1, ack);
      rd_byte(1'b1, rb);    check_value("mr_mem_cleared", rb, 8'h00);
      i2c_stop();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
